tape_arbiter: RTL and testbench
===============================

# tape_arbiter

Sequences and shares the tape RAM of the Brainfuck machine: the 256×7 distributed RAM with one write port (a, d, we) and one asynchronous read port (dpra, dpo). The block sits between that RAM and its users. Users are the interpreter core (read/write), an optional debug dump port (read-only, feeds the UART), and a built-in clear engine that zeroes the whole tape. The block replaces ad-hoc address/we muxing in the top level with one arbitrated, cycle-exact access path.

## Interface
- AW, 8, tape address width
- DW, 7, cell data width
- DEPTH, 256, cells cleared by the clear engine (≤ 2^AW)

- clk  in  1  system clock, all logic on posedge
- rst  in  1  synchronous, active-high reset
- clr_start  in  1  pulse: begin zeroing the tape
- clr_busy  out  1  high while the clear engine owns the RAM
- clr_done  out  1  one-cycle pulse after the last cell is written
- core_req  in  1  core access request, held until granted
- core_we  in  1  1 = write, 0 = read
- core_addr  in  AW  cell address
- core_wdata  in  DW  write data
- core_gnt  out  1  combinational grant, access performed this cycle
- core_rvld  out  1  read data valid, one cycle after a read grant
- core_rdata  out  DW  registered read data
- dump_req  in  1  dump read request, held until granted
- dump_addr  in  AW  cell address
- dump_gnt  out  1  combinational grant
- dump_rvld  out  1  read data valid, one cycle after grant
- dump_rdata  out  DW  registered read data
- ram_a, ram_d, ram_we  out  AW, DW, 1  RAM write port
- ram_dpra  out  AW  RAM read address
- ram_dpo  in  DW  RAM asynchronous read data

## Operation
- States: IDLE, CLEAR. Reset → IDLE, clear counter 0, last-grant flag = DUMP (core wins first tie).
- IDLE, clr_start=1: go to CLEAR the next cycle. No grants are issued in that cycle; requests wait.
- CLEAR: each cycle, ram_we=1, ram_a=cnt, ram_d=0, cnt+1.
  - After writing cnt=DEPTH-1: clr_done=1 in that same cycle, cnt→0, state→IDLE.
  - clr_start is ignored while in CLEAR. No grants are issued; requests stay pending.
- IDLE arbitration: at most one grant per cycle.
  - Only one requester: it is granted.
  - Both requesting: the one not granted last wins (round-robin). The flag updates on every grant.
- Core write grant: ram_we=1, ram_a=core_addr, ram_d=core_wdata. The write commits at that clock edge. No rvld.
- Read grant (core or dump): ram_dpra=addr. ram_dpo is captured into that requester's rdata at the edge, and its rvld=1 for the next cycle.
- rdata holds its value until the next read grant to the same requester.
- Cycles with no write: ram_we=0, ram_a=0, ram_d=0. Cycles with no read grant: ram_dpra=0.
- Write-then-read of the same address in consecutive cycles returns the new value, because the RAM read is asynchronous.
- rst mid-CLEAR: the clear aborts immediately. Cells already written stay 0; the rest are unchanged. clr_done is not pulsed.

## Timing
- Reset values: clr_busy=0, clr_done=0, all gnt=0, rvld=0, rdata=0, ram_we=0, ram_a=0, ram_d=0, ram_dpra=0.
- Grant latency: 0 cycles (combinational from req and state).
- Read latency: 1 cycle after grant.
- Clear duration: exactly DEPTH cycles of ram_we=1. clr_busy is high for those DEPTH cycles only.
- Maximum wait under contention: 1 cycle when both requesters are continuously active.

## Configuration
- TAPE_ARB_DUMP_EN defined: the dump port is active as described above.
- TAPE_ARB_DUMP_EN undefined:
  - dump_req and dump_addr are ignored.
  - dump_gnt, dump_rvld and dump_rdata are tied to 0.
  - The core is granted whenever it requests in IDLE; the round-robin flag logic is removed.

## Test plan
- Reset, then pulse clr_start → clr_busy high for 256 cycles, ram_a runs 0..255 with ram_d=0, clr_done pulses at the write of 255, state returns to IDLE.
- Core writes 0x2A to address 5, then reads address 5 the next cycle → core_rvld=1 one cycle later with core_rdata=0x2A.
- core_req and dump_req held high together for 4 cycles → grants alternate core, dump, core, dump.
- core_req asserted during CLEAR → core_gnt=0 until the cycle after clr_done; the access is then granted with no loss.
- rst asserted at clear cycle 100 → clr_busy=0 the next cycle, no clr_done; cell 99 reads 0 and cell 200 keeps its prior value.
- Build without TAPE_ARB_DUMP_EN, assert dump_req → dump_gnt stays 0 and core accesses are granted every cycle.

Source files
------------

// File: rtl/tape_arbiter.sv
// rtl/tape_arbiter.sv - tape RAM arbiter (core, dump) and clear engine
// Optional dump read port enabled by defining TAPE_ARB_DUMP_EN.
module tape_arbiter #(
    parameter int AW    = 8,
    parameter int DW    = 7,
    parameter int DEPTH = 256
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          clr_start,
    output logic          clr_busy,
    output logic          clr_done,
    input  logic          core_req,
    input  logic          core_we,
    input  logic [AW-1:0] core_addr,
    input  logic [DW-1:0] core_wdata,
    output logic          core_gnt,
    output logic          core_rvld,
    output logic [DW-1:0] core_rdata,
    input  logic          dump_req,
    input  logic [AW-1:0] dump_addr,
    output logic          dump_gnt,
    output logic          dump_rvld,
    output logic [DW-1:0] dump_rdata,
    output logic [AW-1:0] ram_a,
    output logic [DW-1:0] ram_d,
    output logic          ram_we,
    output logic [AW-1:0] ram_dpra,
    input  logic [DW-1:0] ram_dpo
);
    typedef enum logic {IDLE, CLEAR} state_t;
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);

    state_t        state, state_nxt;
    logic [AW-1:0] cnt, cnt_nxt;
    logic          core_rd;

`ifdef TAPE_ARB_DUMP_EN
    logic last_dump, last_dump_nxt;
`else
    logic unused_dump;
    assign unused_dump = ^{dump_req, dump_addr};
`endif

    // rst gates every RAM strobe so an aborted clear writes nothing more
    always_comb begin
        state_nxt = state;
        cnt_nxt   = cnt;
        clr_busy  = 1'b0;
        clr_done  = 1'b0;
        core_gnt  = 1'b0;
        dump_gnt  = 1'b0;
        ram_we    = 1'b0;
        ram_a     = '0;
        ram_d     = '0;
        ram_dpra  = '0;
`ifdef TAPE_ARB_DUMP_EN
        last_dump_nxt = last_dump;
`endif
        if (!rst) begin
            case (state)
                IDLE: begin
                    if (clr_start) begin
                        state_nxt = CLEAR;
                    end else begin
`ifdef TAPE_ARB_DUMP_EN
                        core_gnt = core_req && (!dump_req || last_dump);
                        dump_gnt = dump_req && !core_gnt;
`else
                        core_gnt = core_req;
`endif
                        if (core_gnt) begin
                            if (core_we) begin
                                ram_we = 1'b1;
                                ram_a  = core_addr;
                                ram_d  = core_wdata;
                            end else begin
                                ram_dpra = core_addr;
                            end
                        end
`ifdef TAPE_ARB_DUMP_EN
                        if (dump_gnt) ram_dpra = dump_addr;
                        if (core_gnt) last_dump_nxt = 1'b0;
                        else if (dump_gnt) last_dump_nxt = 1'b1;
`endif
                    end
                end
                CLEAR: begin
                    clr_busy = 1'b1;
                    ram_we   = 1'b1;
                    ram_a    = cnt;
                    if (cnt == LAST) begin
                        clr_done  = 1'b1;
                        cnt_nxt   = '0;
                        state_nxt = IDLE;
                    end else begin
                        cnt_nxt = cnt + AW'(1);
                    end
                end
                default: state_nxt = IDLE;
            endcase
        end
    end

    assign core_rd = core_gnt && !core_we;

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            cnt        <= '0;
            core_rvld  <= 1'b0;
            core_rdata <= '0;
        end else begin
            state     <= state_nxt;
            cnt       <= cnt_nxt;
            core_rvld <= core_rd;
            if (core_rd) core_rdata <= ram_dpo;
        end
    end

`ifdef TAPE_ARB_DUMP_EN
    // last_dump starts set so the core wins the first tie
    always_ff @(posedge clk) begin
        if (rst) begin
            last_dump  <= 1'b1;
            dump_rvld  <= 1'b0;
            dump_rdata <= '0;
        end else begin
            last_dump <= last_dump_nxt;
            dump_rvld <= dump_gnt;
            if (dump_gnt) dump_rdata <= ram_dpo;
        end
    end
`else
    assign dump_rvld  = 1'b0;
    assign dump_rdata = '0;
`endif
endmodule

// File: tb/tb_tape_arbiter.sv
// tb/tb_tape_arbiter.sv - randomized scoreboard bench for tape_arbiter
`timescale 1ns/1ps
module tb_tape_arbiter;
    localparam int AW = 8, DW = 7, DEPTH = 256;
`ifdef TAPE_ARB_DUMP_EN
    localparam bit DUMP_EN = 1'b1;
`else
    localparam bit DUMP_EN = 1'b0;
`endif

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          rst, clr_start, clr_busy, clr_done;
    logic          core_req, core_we, core_gnt, core_rvld;
    logic [AW-1:0] core_addr;
    logic [DW-1:0] core_wdata, core_rdata;
    logic          dump_req, dump_gnt, dump_rvld;
    logic [AW-1:0] dump_addr;
    logic [DW-1:0] dump_rdata;
    logic [AW-1:0] ram_a, ram_dpra;
    logic [DW-1:0] ram_d, ram_dpo;
    logic          ram_we;

    tape_arbiter #(.AW(AW), .DW(DW), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .clr_start(clr_start), .clr_busy(clr_busy), .clr_done(clr_done),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr), .core_wdata(core_wdata),
        .core_gnt(core_gnt), .core_rvld(core_rvld), .core_rdata(core_rdata),
        .dump_req(dump_req), .dump_addr(dump_addr), .dump_gnt(dump_gnt),
        .dump_rvld(dump_rvld), .dump_rdata(dump_rdata),
        .ram_a(ram_a), .ram_d(ram_d), .ram_we(ram_we), .ram_dpra(ram_dpra), .ram_dpo(ram_dpo)
    );

    function automatic logic [DW-1:0] seed_val(input int i);
        return DW'((i * 37 + 11) ^ (i >> 2));
    endfunction

    // tape RAM: asynchronous read, synchronous write, preloaded with a known pattern
    logic [DW-1:0] mem [0:DEPTH-1];
    bit preloaded = 1'b0;
    assign ram_dpo = mem[ram_dpra];
    always @(posedge clk) begin
        if (!preloaded) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= seed_val(i);
            preloaded <= 1'b1;
        end else if (ram_we) begin
            mem[ram_a] <= ram_d;
        end
    end

    int checks = 0, passes = 0;
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    endtask

    // reference model state
    logic [DW-1:0] exp_mem [0:DEPTH-1];
    bit m_clearing, m_last_dump;
    int m_idx;
    bit g_core, g_dump, d_core, d_dump;
    int busy_cnt, done_cnt;

    typedef struct { int due; logic [DW-1:0] data; } rd_t;
    rd_t core_q[$], dump_q[$];
    int cyc = 0;
    logic rst_q = 1'b1;
    bit mon_en = 1'b0;
    always @(posedge clk) begin
        cyc   <= cyc + 1;
        rst_q <= rst;
    end

    logic          s_core_req, s_core_we, s_dump_req;
    logic [AW-1:0] s_core_addr, s_dump_addr;
    logic [DW-1:0] s_core_wdata;

    task automatic step(input bit r, input bit cs);
        logic [27:0]   exp_o, act_o;
        logic          busy, done, we;
        logic [AW-1:0] a, dpra;
        logic [DW-1:0] d;
        rd_t           e;
        @(negedge clk);
        rst = r; clr_start = cs;
        core_req = s_core_req; core_we = s_core_we; core_addr = s_core_addr; core_wdata = s_core_wdata;
        dump_req = s_dump_req; dump_addr = s_dump_addr;
        #1;
        g_core = 0; g_dump = 0; busy = 0; done = 0; we = 0; a = '0; d = '0; dpra = '0;
        if (r) begin
            m_clearing = 0; m_idx = 0; m_last_dump = 1;
        end else if (m_clearing) begin
            busy = 1; we = 1; a = AW'(m_idx); done = (m_idx == DEPTH - 1);
            exp_mem[m_idx] = '0;
            m_idx++;
            if (m_idx == DEPTH) begin m_clearing = 0; m_idx = 0; end
        end else if (cs) begin
            m_clearing = 1;
        end else begin
            if (DUMP_EN && s_core_req && s_dump_req) begin
                g_core = m_last_dump; g_dump = !m_last_dump;
            end else begin
                g_core = s_core_req; g_dump = DUMP_EN && s_dump_req;
            end
            if (g_core) begin
                m_last_dump = 0;
                if (s_core_we) begin
                    we = 1; a = s_core_addr; d = s_core_wdata;
                    exp_mem[s_core_addr] = s_core_wdata;
                end else begin
                    dpra = s_core_addr;
                    e.due = cyc + 1; e.data = exp_mem[s_core_addr];
                    core_q.push_back(e);
                end
            end
            if (g_dump) begin
                m_last_dump = 1;
                dpra = s_dump_addr;
                e.due = cyc + 1; e.data = exp_mem[s_dump_addr];
                dump_q.push_back(e);
            end
        end
        exp_o = {g_core, g_dump, busy, done, we, a, d, dpra};
        act_o = {core_gnt, dump_gnt, clr_busy, clr_done, ram_we, ram_a, ram_d, ram_dpra};
        check("outputs{gnt,gnt,busy,done,we,a,d,dpra}", 32'(act_o), 32'(exp_o));
        d_core = core_gnt; d_dump = dump_gnt;
        if (clr_busy) busy_cnt++;
        if (clr_done) done_cnt++;
    endtask

    // read-data monitor: pops the scoreboard whenever rvld is presented or due
    logic [DW-1:0] core_hold, dump_hold;
    always @(negedge clk) begin
        bit exp_v;
        if (mon_en) begin
            if (rst_q) begin core_hold = '0; dump_hold = '0; end
            exp_v = core_q.size() > 0 && core_q[0].due == cyc;
            if (core_rvld || exp_v) begin
                check("core_rvld", 32'(core_rvld), 32'(exp_v));
                if (exp_v) begin
                    if (core_rvld) check("core_rdata", 32'(core_rdata), 32'(core_q[0].data));
                    core_hold = core_q[0].data;
                    void'(core_q.pop_front());
                end
            end else begin
                check("core_rdata_hold", 32'(core_rdata), 32'(core_hold));
            end
            exp_v = dump_q.size() > 0 && dump_q[0].due == cyc;
            if (dump_rvld || exp_v) begin
                check("dump_rvld", 32'(dump_rvld), 32'(exp_v));
                if (exp_v) begin
                    if (dump_rvld) check("dump_rdata", 32'(dump_rdata), 32'(dump_q[0].data));
                    dump_hold = dump_q[0].data;
                    void'(dump_q.pop_front());
                end
            end else begin
                check("dump_rdata_hold", 32'(dump_rdata), 32'(dump_hold));
            end
        end
    end

    task automatic idle_reqs();
        s_core_req = 0; s_core_we = 0; s_core_addr = '0; s_core_wdata = '0;
        s_dump_req = 0; s_dump_addr = '0;
    endtask

    initial begin
        logic [7:0] seq;
        int k, done_idx;
        bit r, cs;
        for (int i = 0; i < DEPTH; i++) exp_mem[i] = seed_val(i);
        m_clearing = 0; m_idx = 0; m_last_dump = 1;
        rst = 1; clr_start = 0; core_req = 0; core_we = 0; core_addr = '0; core_wdata = '0;
        dump_req = 0; dump_addr = '0;
        idle_reqs();
        repeat (3) step(1, 0);
        mon_en = 1;
        step(0, 0);
        check("rst_core_rvld", 32'(core_rvld), 0);
        check("rst_core_rdata", 32'(core_rdata), 0);
        check("rst_dump_rdata", 32'(dump_rdata), 0);
        check("rst_clr_busy", 32'(clr_busy), 0);

        // both requesters held together right after reset
        s_core_req = 1; s_core_addr = 8'd3; s_dump_req = 1; s_dump_addr = 8'd4;
        seq = '0;
        for (int i = 0; i < 4; i++) begin
            step(0, 0);
            seq = {seq[5:0], d_core, d_dump};
        end
        check("rr_sequence", 32'(seq), DUMP_EN ? 32'b10_01_10_01 : 32'b10_10_10_10);
        idle_reqs();
        step(0, 0);

        // write 0x2A to cell 5, read it back the next cycle
        s_core_req = 1; s_core_we = 1; s_core_addr = 8'd5; s_core_wdata = 7'h2A;
        step(0, 0);
        s_core_we = 0;
        step(0, 0);
        idle_reqs();
        step(0, 0);
        check("wr_rd_rvld", 32'(core_rvld), 1);
        check("wr_rd_data", 32'(core_rdata), 32'h2A);

        // seed cells 99 and 200, then abort a clear after 100 writes
        s_core_req = 1; s_core_we = 1; s_core_addr = 8'd99; s_core_wdata = 7'h11;
        step(0, 0);
        s_core_addr = 8'd200; s_core_wdata = 7'h55;
        step(0, 0);
        idle_reqs();
        done_cnt = 0;
        step(0, 1);
        repeat (100) step(0, 0);
        step(1, 0);
        step(0, 0);
        check("abort_busy_low", 32'(clr_busy), 0);
        check("abort_no_done", 32'(done_cnt), 0);
        s_core_req = 1; s_core_addr = 8'd99;
        step(0, 0);
        s_core_addr = 8'd200;
        step(0, 0);
        idle_reqs();
        check("abort_cell99", 32'(core_rdata), 0);
        step(0, 0);
        check("abort_cell200", 32'(core_rdata), 32'h55);

        // full clear with a core read arriving during CLEAR
        busy_cnt = 0; done_cnt = 0; done_idx = -1;
        step(0, 1);
        s_core_req = 1; s_core_addr = 8'd7;
        k = 0;
        while (k < 400) begin
            step(0, 0);
            if (clr_done) done_idx = k;
            if (d_core) break;
            k++;
        end
        idle_reqs();
        check("clr_gnt_wait", 32'(k), 256);
        check("clr_busy_cycles", 32'(busy_cnt), 256);
        check("clr_done_index", 32'(done_idx), 255);
        check("clr_done_count", 32'(done_cnt), 1);
        step(0, 0);

        // randomized traffic with occasional clears and resets
        g_core = 0; g_dump = 0;
        for (int i = 0; i < 3000; i++) begin
            if (!s_core_req || g_core) begin
                s_core_req   = ($urandom % 4) != 0;
                s_core_we    = 1'($urandom % 2);
                s_core_addr  = ($urandom % 3 == 0) ? AW'($urandom) : AW'($urandom % 8);
                s_core_wdata = DW'($urandom);
            end
            if (!s_dump_req || g_dump) begin
                s_dump_req  = ($urandom % 3) != 0;
                s_dump_addr = ($urandom % 3 == 0) ? AW'($urandom) : AW'($urandom % 8);
            end
            r  = ($urandom % 1000) == 0;
            cs = ($urandom % 300) == 0;
            step(r, cs);
        end
        idle_reqs();
        repeat (3) step(0, 0);
        check("scoreboard_core_drained", 32'(core_q.size()), 0);
        check("scoreboard_dump_drained", 32'(dump_q.size()), 0);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end
endmodule
